// File: rtl/fil_campaign_pkg.sv
// Shared types and limits for the stuck-at fault campaign controller.
package fil_campaign_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        UPDATE,
        SETTLE,
        DONE
    } state_e;

    localparam int CMP_LAT_MIN = 1;
    localparam int CMP_LAT_MAX = 8;

    // At least one bit so PATS=1 still yields a legal index port.
    function automatic int idx_w(input int pats);
        return (pats > 1) ? $clog2(pats) : 1;
    endfunction

endpackage

// File: rtl/fil_vpipe.sv
// Latency-compensation shift register carrying {valid, pattern index} to the compare point.
module fil_vpipe
    import fil_campaign_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int IW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vld_i,
    input  logic [IW-1:0] idx_i,
    output logic          vld_o,
    output logic [IW-1:0] idx_o,
    output logic          pend_o
);

    logic [DEPTH-1:0]         vld_q;
    logic [DEPTH-1:0][IW-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            idx_q[0] <= idx_i;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
                idx_q[k] <= idx_q[k-1];
            end
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign idx_o = idx_q[DEPTH-1];

    // Patterns still in flight behind the one being compared this cycle.
    generate
        if (DEPTH > 1) begin : g_pend
            assign pend_o = |vld_q[DEPTH-2:0];
        end else begin : g_nopend
            assign pend_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/fil_campaign_ctrl.sv
// Stuck-at fault campaign sequencer: drives patterns per fault, scores detection, steps the FIL.
module fil_campaign_ctrl
    import fil_campaign_pkg::*;
#(
    parameter int OUT_BITS   = 32,
    parameter int PATS       = 16,
    parameter int CMP_LAT    = 1,
    parameter int EARLY_EXIT = 1,
    parameter int CNT_W      = 16,
    parameter int IDX_W      = idx_w(PATS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                FIL_END,
    input  logic [OUT_BITS-1:0] CUT_OP,
    input  logic [OUT_BITS-1:0] FF_OP,
    input  logic [OUT_BITS-1:0] OUT_MASK,
    output logic                FIL_INC,
    output logic                pat_en,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    fault_cnt,
    output logic [CNT_W-1:0]    det_cnt,
    output logic [IDX_W-1:0]    last_det_pat
);

    localparam int LAT = (CMP_LAT < CMP_LAT_MIN) ? CMP_LAT_MIN :
                         (CMP_LAT > CMP_LAT_MAX) ? CMP_LAT_MAX : CMP_LAT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   pat_idx_q, pat_idx_d;
    logic               det_flag_q, det_flag_d;
    logic [CNT_W-1:0]   fault_cnt_q, fault_cnt_d;
    logic [CNT_W-1:0]   det_cnt_q, det_cnt_d;
    logic [IDX_W-1:0]   ldp_q, ldp_d;

    logic               cmp_vld;
    logic [IDX_W-1:0]   cmp_idx;
    logic               pipe_pend;
    logic               mismatch;

    fil_vpipe #(
        .DEPTH (LAT),
        .IW    (IDX_W)
    ) u_vpipe (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (pat_en),
        .idx_i  (pat_idx_q),
        .vld_o  (cmp_vld),
        .idx_o  (cmp_idx),
        .pend_o (pipe_pend)
    );

    assign mismatch = cmp_vld & (|((CUT_OP ^ FF_OP) & OUT_MASK));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pat_idx_q   <= '0;
            det_flag_q  <= 1'b0;
            fault_cnt_q <= '0;
            det_cnt_q   <= '0;
            ldp_q       <= '0;
        end else begin
            state_q     <= state_d;
            pat_idx_q   <= pat_idx_d;
            det_flag_q  <= det_flag_d;
            fault_cnt_q <= fault_cnt_d;
            det_cnt_q   <= det_cnt_d;
            ldp_q       <= ldp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pat_idx_d   = pat_idx_q;
        det_flag_d  = det_flag_q;
        fault_cnt_d = fault_cnt_q;
        det_cnt_d   = det_cnt_q;
        ldp_d       = ldp_q;
        pat_en      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        FIL_INC     = 1'b0;

        // Only the first detecting pattern of a fault is recorded.
        if (mismatch && !det_flag_q) begin
            det_flag_d = 1'b1;
            ldp_d      = cmp_idx;
        end

        case (state_q)
            IDLE: begin
                fault_cnt_d = '0;
                det_cnt_d   = '0;
                ldp_d       = '0;
                pat_idx_d   = '0;
                det_flag_d  = 1'b0;
                if (start) state_d = RUN;
            end
            RUN: begin
                pat_en    = 1'b1;
                busy      = 1'b1;
                pat_idx_d = pat_idx_q + 1'b1;
                if (pat_idx_q == LAST_IDX || (EARLY_EXIT != 0 && det_flag_q))
                    state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!pipe_pend) state_d = UPDATE;
            end
            UPDATE: begin
                busy = 1'b1;
                if (fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + 1'b1;
                if (det_flag_q && det_cnt_q != '1) det_cnt_d = det_cnt_q + 1'b1;
                if (FIL_END) begin
                    state_d = DONE;
                end else begin
                    FIL_INC = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                busy       = 1'b1;
                det_flag_d = 1'b0;
                pat_idx_d  = '0;
                state_d    = RUN;
            end
            DONE: begin
                done = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fault_cnt    = fault_cnt_q;
    assign det_cnt      = det_cnt_q;
    assign last_det_pat = ldp_q;

endmodule

// File: tb/tb_fil_campaign_ctrl.sv
// Directed bench: four parameter sets run side by side, each with a FIL/CUT model and a cycle-level schedule model.
module tb_fil_campaign_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_fin   = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int NSCN = 10;

    typedef struct {
        int          cfg;
        int          nf;
        logic [31:0] mask;
        logic [63:0] mm;       // byte f = fault f, bit p = pattern p mismatches
        int          bitn;
        int          rst_at;   // schedule cycle to assert rst, -1 = none
        int          start_rst;
        int          e_fc;
        int          e_dc;
        int          e_ldp;
        int          e_pats;
        int          e_gap;    // cycles between first two FIL_INC, -1 = skip
    } scn_t;

    typedef struct packed {
        logic        pe;
        logic        inc;
        logic        bsy;
        logic        dn;
        logic [15:0] fc;
        logic [15:0] dc;
        logic [7:0]  ldp;
    } ex_t;

    function automatic int c_pats(input int g); return (g == 3) ? 1 : 4; endfunction
    function automatic int c_lat(input int g);  return (g == 2) ? 3 : (g == 3) ? 2 : 1; endfunction
    function automatic int c_ee(input int g);   return (g == 1 || g == 3) ? 1 : 0; endfunction
    function automatic int c_cw(input int g);   return (g == 3) ? 2 : 16; endfunction
    function automatic int c_ob(input int g);   return (g == 3) ? 8 : 32; endfunction

    function automatic scn_t mk(input int cfg, input int nf, input logic [31:0] mask,
                                input logic [63:0] mm, input int bitn, input int rst_at,
                                input int start_rst, input int e_fc, input int e_dc,
                                input int e_ldp, input int e_pats, input int e_gap);
        scn_t s;
        s.cfg = cfg; s.nf = nf; s.mask = mask; s.mm = mm; s.bitn = bitn;
        s.rst_at = rst_at; s.start_rst = start_rst; s.e_fc = e_fc; s.e_dc = e_dc;
        s.e_ldp = e_ldp; s.e_pats = e_pats; s.e_gap = e_gap;
        return s;
    endfunction

    function automatic scn_t get_scn(input int i);
        case (i)
            0: return mk(0, 3, 32'hFFFF_FFFF, 64'h0,         5, -1, 0, 3, 0, 0, 12, 7);
            1: return mk(0, 3, 32'hFFFF_FFFF, 64'h0400,      5, -1, 0, 3, 1, 2, 12, 7);
            2: return mk(0, 3, 32'hFFFF_FFDF, 64'h0400,      5, -1, 0, 3, 0, 0, 12, 7);
            3: return mk(0, 3, 32'hFFFF_FFFF, 64'h01000A,    0, -1, 1, 3, 2, 0, 12, 7);
            4: return mk(0, 3, 32'hFFFF_FFFF, 64'h02,        5,  9, 0, 3, 1, 1, 12, 7);
            5: return mk(0, 3, 32'h0,         64'hFFFFFF,    5, -1, 0, 3, 0, 0, 12, 7);
            6: return mk(1, 3, 32'hFFFF_FFFF, 64'h0400,      5, -1, 0, 3, 1, 2, 12, 7);
            7: return mk(1, 3, 32'hFFFF_FFFF, 64'h0100,      5, -1, 0, 3, 1, 0, 11, 6);
            8: return mk(2, 3, 32'hFFFF_FFFF, 64'h08,        5, -1, 0, 3, 1, 3, 12, 9);
            default: return mk(3, 5, 32'hFFFF_FFFF, 64'h0101010101, 7, -1, 0, 3, 3, 0, 5, 5);
        endcase
    endfunction

    // First pattern of fault f that exposes the fault at an unmasked bit, -1 if none.
    function automatic int first_det(input scn_t sc, input int f, input int pats);
        if (!sc.mask[sc.bitn]) return -1;
        for (int p = 0; p < pats; p++)
            if (sc.mm[f*8 + p]) return p;
        return -1;
    endfunction

    // Expected outputs at cycle t after the start cycle. Per fault: n RUN cycles,
    // lat DRAIN cycles, one UPDATE, one SETTLE (none after the last fault).
    function automatic ex_t model_at(input scn_t sc, input int pats, input int lat,
                                     input int ee, input int cw, input int t);
        ex_t e;
        int base, fc, dc, ldp, d, n, len, c, cmax;
        e = '0; base = 0; fc = 0; dc = 0; ldp = 0;
        cmax = (1 << cw) - 1;
        for (int f = 0; f < sc.nf; f++) begin
            d = first_det(sc, f, pats);
            n = (ee != 0 && d >= 0 && d + lat + 2 < pats) ? d + lat + 2 : pats;
            len = n + lat + ((f == sc.nf - 1) ? 1 : 2);
            if (t < base + len) begin
                c = t - base;
                if (d >= 0 && c >= d + lat + 1) ldp = d;
                if (c == n + lat + 1) begin
                    fc = (fc < cmax) ? fc + 1 : fc;
                    if (d >= 0) dc = (dc < cmax) ? dc + 1 : dc;
                end
                e.pe  = (c < n);
                e.inc = (c == n + lat) && (f != sc.nf - 1);
                e.bsy = 1'b1;
                e.fc  = 16'(fc); e.dc = 16'(dc); e.ldp = 8'(ldp);
                return e;
            end
            if (d >= 0) ldp = d;
            fc = (fc < cmax) ? fc + 1 : fc;
            if (d >= 0) dc = (dc < cmax) ? dc + 1 : dc;
            base += len;
        end
        e.dn = 1'b1;
        e.fc = 16'(fc); e.dc = 16'(dc); e.ldp = 8'(ldp);
        return e;
    endfunction

    task automatic chk(input int g, input int s, input string nm,
                       input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL cfg%0d scn%0d %s: got %0d expected %0d", g, s, nm, act, req);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : G
        localparam int PP = c_pats(g);
        localparam int LL = c_lat(g);
        localparam int EE = c_ee(g);
        localparam int CW = c_cw(g);
        localparam int OB = c_ob(g);
        localparam int IW = (PP > 1) ? $clog2(PP) : 1;

        logic          rst_g, start_g, fil_end, fil_inc, pe, bsy, dn;
        logic [OB-1:0] cut, ffo, msk;
        logic [CW-1:0] fc, dc;
        logic [IW-1:0] ldp;

        fil_campaign_ctrl #(
            .OUT_BITS(OB), .PATS(PP), .CMP_LAT(LL), .EARLY_EXIT(EE), .CNT_W(CW)
        ) dut (
            .clk(clk), .rst(rst_g), .start(start_g), .FIL_END(fil_end),
            .CUT_OP(cut), .FF_OP(ffo), .OUT_MASK(msk),
            .FIL_INC(fil_inc), .pat_en(pe), .busy(bsy), .done(dn),
            .fault_cnt(fc), .det_cnt(dc), .last_det_pat(ldp)
        );

        // FIL and CUT environment: which (fault, pattern) reaches the compare this cycle.
        int          fidx, pcnt;
        logic [LL:1] pv;
        int          pf  [1:LL];
        int          ppi [1:LL];
        logic [63:0] cur_mm;
        int          cur_bit, cur_nf, sid;
        logic [31:0] h;
        int          mi;

        always @(posedge clk) begin
            if (rst_g) begin
                fidx <= 0; pcnt <= 0; pv <= '0;
                for (int k = 1; k <= LL; k++) begin pf[k] <= 0; ppi[k] <= 0; end
            end else begin
                if (fil_inc) begin fidx <= fidx + 1; pcnt <= 0; end
                else if (pe) pcnt <= pcnt + 1;
                pv[1] <= pe; pf[1] <= fidx; ppi[1] <= pcnt;
                for (int k = 2; k <= LL; k++) begin
                    pv[k] <= pv[k-1]; pf[k] <= pf[k-1]; ppi[k] <= ppi[k-1];
                end
            end
        end

        assign fil_end = (fidx == cur_nf - 1);

        // Outside valid compare slots the CUT output is deliberately garbage.
        always_comb begin
            h   = 32'(cyc) * 32'h9E37_79B9;
            mi  = pf[LL] * 8 + ppi[LL];
            ffo = h[OB-1:0];
            cut = ~h[OB-1:0];
            if (pv[LL]) begin
                cut = h[OB-1:0];
                if (mi >= 0 && mi < 64 && cur_mm[mi[5:0]]) cut = h[OB-1:0] ^ (OB'(1) << cur_bit);
            end
        end

        ex_t         exp_c;
        logic        chk_en;
        int          pe_cnt, inc1, inc2, sc_cyc;
        logic [31:0] s_fc, s_dc, s_ldp;

        always @(negedge clk) begin
            if (chk_en) begin
                chk(g, sid, "pat_en",       32'(pe),      32'(exp_c.pe));
                chk(g, sid, "FIL_INC",      32'(fil_inc), 32'(exp_c.inc));
                chk(g, sid, "busy",         32'(bsy),     32'(exp_c.bsy));
                chk(g, sid, "done",         32'(dn),      32'(exp_c.dn));
                chk(g, sid, "fault_cnt",    32'(fc),      32'(exp_c.fc));
                chk(g, sid, "det_cnt",      32'(dc),      32'(exp_c.dc));
                chk(g, sid, "last_det_pat", 32'(ldp),     32'(exp_c.ldp));
            end
        end

        task automatic step(input ex_t e, input logic ck, input logic st, input logic r);
            #1;
            rst_g = r; start_g = st; exp_c = e; chk_en = ck;
            @(negedge clk);
            #1;
            if (pe) pe_cnt++;
            if (fil_inc) begin
                if (inc1 < 0) inc1 = sc_cyc;
                else if (inc2 < 0) inc2 = sc_cyc;
            end
            s_fc = 32'(fc); s_dc = 32'(dc); s_ldp = 32'(ldp);
            sc_cyc++;
            @(posedge clk);
        endtask

        task automatic campaign(input scn_t sc, input int ra);
            ex_t e;
            int  t;
            pe_cnt = 0; inc1 = -1; inc2 = -1; sc_cyc = 0;
            step('0, 1'b1, 1'b1, 1'b0);
            t = 0;
            while (t < 1000) begin
                e = model_at(sc, PP, LL, EE, CW, t);
                if (ra >= 0 && t == ra) begin
                    step(e, 1'b1, 1'b0, 1'b1);
                    return;
                end
                if (e.dn) break;
                step(e, 1'b1, 1'b0, 1'b0);
                t++;
            end
            // Hold in DONE; a start pulse here must be ignored.
            for (int k = 0; k < 4; k++)
                step(model_at(sc, PP, LL, EE, CW, t + k), 1'b1, (k == 1), 1'b0);
        endtask

        initial begin
            scn_t sc;
            rst_g = 1'b1; start_g = 1'b0; msk = '0; chk_en = 1'b0; exp_c = '0;
            cur_mm = '0; cur_bit = 0; cur_nf = 1; sid = -1;
            pe_cnt = 0; inc1 = -1; inc2 = -1; sc_cyc = 0;
            s_fc = '0; s_dc = '0; s_ldp = '0;
            @(posedge clk);
            for (int s = 0; s < NSCN; s++) begin
                sc = get_scn(s);
                if (sc.cfg == g) begin
                    sid = s; cur_mm = sc.mm; cur_bit = sc.bitn; cur_nf = sc.nf;
                    msk = sc.mask[OB-1:0];
                    step('0, 1'b0, 1'(sc.start_rst), 1'b1);
                    step('0, 1'b1, 1'b0, 1'b0);
                    campaign(sc, sc.rst_at);
                    if (sc.rst_at >= 0) begin
                        step('0, 1'b1, 1'b0, 1'b0);
                        campaign(sc, -1);
                    end
                    chk(g, s, "final fault_cnt",    s_fc,  sc.e_fc);
                    chk(g, s, "final det_cnt",      s_dc,  sc.e_dc);
                    chk(g, s, "final last_det_pat", s_ldp, sc.e_ldp);
                    chk(g, s, "pat_en cycles",      pe_cnt, sc.e_pats);
                    if (sc.e_gap >= 0) chk(g, s, "FIL_INC spacing", inc2 - inc1, sc.e_gap);
                end
            end
            n_fin++;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && n_fin < 4; i++) @(posedge clk);
        if (n_fin < 4) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got %0d configs finished expected 4", n_fin);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fil_campaign_ctrl.md
Name: fil_campaign_ctrl

Overview:
- Parametrised successor to the fault-injection mid section.
- Sequences a full stuck-at fault campaign. Per injected fault it:
  - drives a fixed number of test patterns;
  - compares the faulty CUT output against the fault-free CUT output, with pipeline-latency compensation;
  - records detection;
  - pulses FIL_INC to advance the FIL, stopping at FIL_END.
- Sits between the pattern generator (LFSR), the FIL/CUT pair and the coverage readout.

Parameters:
- OUT_BITS, 32, CUT output width compared.
- PATS, 16, patterns applied per fault (>=1).
- CMP_LAT, 1, cycles from pat_en to valid CUT/FF outputs at the compare (1..8).
- EARLY_EXIT, 1, 1 = abandon remaining patterns for a fault once it is detected.
- CNT_W, 16, width of fault/detect counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  campaign start pulse; honoured only in IDLE.
- FIL_END  in  1  FIL reports the last fault is injected.
- CUT_OP  in  OUT_BITS  faulty CUT output.
- FF_OP  in  OUT_BITS  fault-free CUT output.
- OUT_MASK  in  OUT_BITS  1 = bit compared; 0 = ignored.
- FIL_INC  out  1  one-cycle pulse; FIL injects the next fault.
- pat_en  out  1  pattern generator advance / pattern valid this cycle.
- busy  out  1  campaign in progress.
- done  out  1  campaign finished; held.
- fault_cnt  out  CNT_W  faults evaluated.
- det_cnt  out  CNT_W  faults detected.
- last_det_pat  out  $clog2(PATS)  pattern index that first detected the most recent detected fault.

Behaviour:
- Reset: the one clock is clk; reset is rst, synchronous and active-high.
  - On rst: state=IDLE; all outputs 0; internal pat_idx, det_flag, valid pipe and idx pipe all cleared.
  - rst mid-campaign aborts immediately. The FIL is reset by the same rst.
- States: IDLE, RUN, DRAIN, UPDATE, SETTLE, DONE.
- IDLE:
  - start=1 -> RUN.
  - fault_cnt, det_cnt, last_det_pat := 0; pat_idx := 0; det_flag := 0.
- RUN:
  - pat_en=1 every cycle; pat_idx increments.
  - Leave to DRAIN after the cycle pat_idx==PATS-1 is issued, or earlier if EARLY_EXIT && det_flag.
  - pat_en is 0 from the first DRAIN cycle.
- Compare path:
  - cmp_valid = pat_en delayed CMP_LAT cycles.
  - cmp_idx = pat_idx delayed CMP_LAT cycles.
  - mismatch = cmp_valid & |((CUT_OP ^ FF_OP) & OUT_MASK).
  - On mismatch with det_flag==0: det_flag:=1 and last_det_pat:=cmp_idx on the next edge.
  - Later mismatches for the same fault change nothing.
- DRAIN: stays until the valid pipe is empty, i.e. CMP_LAT cycles after the last pat_en. In-flight mismatches are still scored, including under early exit.
- UPDATE (1 cycle):
  - fault_cnt += 1; det_cnt += det_flag. Both saturate at 2^CNT_W-1.
  - If FIL_END=1 -> DONE.
  - Else FIL_INC=1 this cycle only -> SETTLE.
- SETTLE (1 cycle): det_flag := 0, pat_idx := 0 -> RUN. Gives the FIL one cycle to apply the new fault.
- DONE:
  - done=1, busy=0; counters held.
  - start ignored; only rst leaves DONE.
- busy=1 in RUN, DRAIN, UPDATE, SETTLE.
- FIL_END is sampled only in UPDATE.
- Timing per fault without early exit: PATS + CMP_LAT + 2 cycles.
- Boundaries:
  - OUT_MASK=0 means no detection ever.
  - PATS=1 leaves RUN after one cycle.
  - Mismatch on the final pattern is detected (scored in DRAIN).
  - A start pulse coinciding with rst is ignored (rst wins).

Decomposition:
- Package fil_campaign_pkg holds the state enum (IDLE..DONE) and the CMP_LAT range limits.
- One sub-module, fil_vpipe: a CMP_LAT-deep shift register carrying {valid, pat_idx}, synchronous reset clears it.

Test Plan:
- PATS=4, CMP_LAT=1, 3 faults, CUT_OP==FF_OP always:
  - FIL_INC pulses twice, 7 cycles apart;
  - done after the third UPDATE; fault_cnt=3, det_cnt=0.
- Fault 1 mismatch on bit 5 at pattern 2, OUT_MASK=all ones, EARLY_EXIT=0:
  - det_cnt=1, last_det_pat=2;
  - fault 1 still uses 4 pat_en cycles.
- Same stimulus with EARLY_EXIT=1: fault 1 pat_en stops after pattern 3 is issued; det_cnt=1.
- Mismatch only on bit 5 with OUT_MASK bit 5=0 -> det_cnt=0.
- CMP_LAT=3, mismatch only on the last pattern (idx 3) -> detected in DRAIN; det_cnt=1, last_det_pat=3.
- rst asserted during RUN of fault 2:
  - next cycle all outputs 0, state IDLE;
  - start restarts with fault_cnt=0.
